multisim_server_pull: RTL and testbench

Simulation-side receive endpoint of a multisim server channel: polls a named DPI server for words produced by a remote client and presents them to the local design as a valid/ready stream. It is the counterpart of the push endpoint, carrying data from the client into the server-side simulation. A DEPTH-entry prefetch FIFO decouples DPI polling from downstream backpressure, so one word can be accepted from DPI and one delivered downstream in the same cycle.

---
 rtl/multisim_server_pull_if.sv | 62 ++++++
 rtl/multisim_server_pull.sv | 74 +++++++
 tb/tb_multisim_server_pull.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multisim_server_pull_if.sv
// Stream bundle for multisim_server_pull plus the server-channel access functions.
// The server functions front a word store that the client side of the channel fills.
interface multisim_server_pull_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned SRV_SLOTS  = 1024
);
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(SRV_SLOTS);

   logic                  data_vld;
   logic                  data_rdy;
   logic [DATA_WIDTH-1:0] data;
   logic [LW-1:0]         level;

   // Server-side state mirrors what the DPI server keeps in software, hence 2-state types.
   bit   [DATA_WIDTH-1:0] srv_mem [SRV_SLOTS];
   int unsigned           srv_wr;
   int unsigned           srv_rd;
   int unsigned           call_cnt;
   int unsigned           start_cnt;
   string                 srv_name;

   function automatic void multisim_server_start(input string name);
      srv_name  = name;
      start_cnt = start_cnt + 1;
   endfunction

   function automatic int multisim_server_get_data(input string name,
                                                   output bit [DATA_WIDTH-1:0] d,
                                                   input int data_width);
      call_cnt = call_cnt + 1;
      d        = '0;
      if (name != srv_name || data_width != int'(DATA_WIDTH) || srv_rd == srv_wr)
         return 0;
      d      = srv_mem[srv_rd[SW-1:0]];
      srv_rd = srv_rd + 1;
      return 1;
   endfunction

   function automatic void client_send(input logic [DATA_WIDTH-1:0] w);
      srv_mem[srv_wr[SW-1:0]] = w;
      srv_wr                  = srv_wr + 1;
   endfunction

   modport master (
      output data_vld,
      output data,
      output level,
      input  data_rdy,
      import multisim_server_start,
      import multisim_server_get_data
   );

   modport slave (
      input  data_vld,
      input  data,
      input  level,
      output data_rdy,
      import client_send
   );
endinterface

// File: rtl/multisim_server_pull.sv
// Receive endpoint of a multisim server channel: polls the server once per cycle
// into a DEPTH-entry prefetch FIFO and presents the head word as a valid/ready stream.
module multisim_server_pull #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  string                  server_name,
   multisim_server_pull_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_q;
   logic [PW-1:0]         rd_q;
   logic [PW-1:0]         rd_d;
   logic [CW-1:0]         count_q;
   logic                  started_q;
   logic                  vld;
   logic                  pop;
   logic                  poll;

   always_comb begin
      vld  = (count_q != '0);
      pop  = vld && bus.data_rdy;
      poll = (started_q === 1'b1) && rst_n && ((count_q < CW'(DEPTH)) || pop);
      rd_d = pop ? rd_q + 1'b1 : rd_q;
   end

   always_comb begin
      bus.data_vld = vld;
      bus.data     = vld ? mem_q[rd_q] : '0;
      bus.level    = count_q;
   end

   // Server start is independent of rst_n: once started it is never restarted.
   always_ff @(posedge clk) begin
      if (started_q !== 1'b1 && server_name != "") begin
         bus.multisim_server_start(server_name);
         started_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin : fifo_update
      logic [DATA_WIDTH-1:0] word;
      logic                  got;
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q <= rd_d;
         if (poll) begin
            got = (bus.multisim_server_get_data(server_name, word, int'(DATA_WIDTH)) & 1) != 0;
            if (got) begin
               mem_q[wr_q] <= word;
               wr_q        <= wr_q + 1'b1;
               count_q     <= pop ? count_q : count_q + 1'b1;
            end else begin
               count_q     <= pop ? count_q - 1'b1 : count_q;
            end
         end else begin
            count_q <= pop ? count_q - 1'b1 : count_q;
         end
      end
   end

   a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
      bus.data_vld && !bus.data_rdy |=> bus.data_vld && $stable(bus.data));

   a_level_bound: assert property (@(posedge clk) bus.level <= CW'(DEPTH));
endmodule

// File: tb/tb_multisim_server_pull.sv
// Bench for multisim_server_pull: directed scenarios plus a random phase, every cycle
// compared against a queue-based model of the server and the prefetch FIFO.
module tb_multisim_server_pull;
   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 4;

   logic  clk;
   logic  rst_n;
   string server_name;

   int unsigned n_cmp;
   int unsigned n_err;

   logic [DW-1:0] m_srv[$];
   logic [DW-1:0] m_fifo[$];
   bit            m_started;
   int unsigned   m_calls;
   int unsigned   m_starts;

   multisim_server_pull_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   multisim_server_pull #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .server_name (server_name),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [DW-1:0] w);
      bus.client_send(w);
      m_srv.push_back(w);
   endtask

   // One clock: update the model on the edge, compare outputs on the following negedge.
   task automatic step();
      bit was_started;
      bit do_pop;
      bit do_poll;
      @(posedge clk);
      was_started = m_started;
      if (!m_started && server_name != "") begin
         m_started = 1'b1;
         m_starts++;
      end
      if (!rst_n) begin
         m_fifo.delete();
      end else begin
         do_pop  = (m_fifo.size() != 0) && bus.data_rdy;
         do_poll = was_started && ((m_fifo.size() < DEPTH) || do_pop);
         if (do_pop) void'(m_fifo.pop_front());
         if (do_poll) begin
            m_calls++;
            if (m_srv.size() != 0) m_fifo.push_back(m_srv.pop_front());
         end
      end
      @(negedge clk);
      check_eq("data_vld", 64'(bus.data_vld), 64'(m_fifo.size() != 0));
      check_eq("data", bus.data, (m_fifo.size() != 0) ? m_fifo[0] : 64'h0);
      check_eq("level", 64'(bus.level), 64'(m_fifo.size()));
      check_eq("get_calls", 64'(bus.call_cnt), 64'(m_calls));
      check_eq("start_calls", 64'(bus.start_cnt), 64'(m_starts));
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      m_started   = 1'b0;
      m_calls     = 0;
      m_starts    = 0;
      rst_n       = 1'b0;
      server_name = "";
      bus.data_rdy = 1'b0;
      @(negedge clk);
      run(2);

      // Late server name: words queued by the client must wait for the start.
      rst_n = 1'b1;
      send(64'h5A);
      run(10);
      server_name = "mss0";
      bus.data_rdy = 1'b1;
      run(4);

      // Basic flow
      send(64'h11); send(64'h22); send(64'h33);
      run(6);

      // Backpressure fill then drain
      bus.data_rdy = 1'b0;
      for (int unsigned i = 0; i < 6; i++) send(64'hA0 + 64'(i));
      run(8);
      bus.data_rdy = 1'b1;
      run(8);

      // Full FIFO with simultaneous push/pop across several wraps
      bus.data_rdy = 1'b0;
      for (int unsigned i = 0; i < 4; i++) send(64'hB0 + 64'(i));
      run(6);
      for (int unsigned i = 0; i < 12; i++) send(64'hC0 + 64'(i));
      bus.data_rdy = 1'b1;
      run(18);

      // Sparse server
      for (int unsigned i = 0; i < 5; i++) begin
         send(64'hD0 + 64'(i));
         run(3);
      end

      // Reset mid-operation with a word queued in the server during reset
      bus.data_rdy = 1'b0;
      send(64'h01); send(64'h02); send(64'h03);
      run(5);
      rst_n = 1'b0;
      send(64'h04);
      run(2);
      rst_n = 1'b1;
      bus.data_rdy = 1'b1;
      run(4);

      // Random traffic with occasional resets
      for (int unsigned i = 0; i < 400; i++) begin
         bus.data_rdy = ($urandom_range(0, 3) != 0);
         rst_n        = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 2) != 0) send({$urandom, $urandom});
         step();
      end
      rst_n        = 1'b1;
      bus.data_rdy = 1'b1;
      run(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
